perceptron_predictor_v2: RTL and testbench

Parametrised perceptron branch predictor for the 16-bit MIPS-style pipeline. It replaces the fixed single-history perceptron.
- Configurable global history length, table depth and weight width.
- Training threshold THETA.
- Speculative global history register (GHR) with checkpoint restore on mispredict.
- IF issues a lookup with the fetch PC. The prediction returns one cycle later.
- EX returns the resolved outcome, together with the sum and history snapshot that travelled down IF_ID/ID_EX, for training.

---
 rtl/perceptron_predictor_v2.sv | 229 ++++++++++++++++++++++
 tb/tb_perceptron_predictor_v2.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_predictor_v2.sv
// -----------------------------------------------------------------------------
// perceptron_predictor_v2
//
// Parametrised perceptron branch predictor with a speculative global history
// register (GHR) and checkpoint restore on mispredict.
//
// A lookup issued with pred_valid/pred_pc is answered one cycle later on the
// registered pred_* outputs. The resolved branch comes back on upd_*, together
// with the sum and history snapshot it was predicted with. Those values drive
// training and the GHR restore.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   pred_valid     lookup request this cycle
//   pred_pc        fetch PC for the lookup
//   pred_out_valid registered: prediction outputs valid
//   pred_taken     registered: 1 = predict taken
//   pred_sum       registered: signed perceptron output
//   pred_hist      registered: GHR snapshot used for the lookup
//   upd_valid      resolved branch from EX
//   upd_pc         PC of the resolved branch
//   upd_taken      actual outcome
//   upd_sum        pred_sum carried with the branch
//   upd_hist       pred_hist carried with the branch
//   mispredict     combinational: resolved outcome differs from prediction
//
// Optional feature, enabled by defining the macro PERCEPTRON_STATS_EN:
//   stat_lookups, stat_updates, stat_mispredicts, stat_trains
//   These are free-running CNT_WIDTH event counters that wrap.
// -----------------------------------------------------------------------------
module perceptron_predictor_v2 #(
    parameter int PC_WIDTH   = 8,
    parameter int LUT_DEPTH  = 32,
    parameter int HISTORY    = 4,
    parameter int WIDTH_WORD = 4,
    parameter int SUM_WIDTH  = 8,
    parameter int THETA      = 21,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pred_valid,
    input  logic [PC_WIDTH-1:0]  pred_pc,
    output logic                 pred_out_valid,
    output logic                 pred_taken,
    output logic [SUM_WIDTH-1:0] pred_sum,
    output logic [HISTORY-1:0]   pred_hist,
    input  logic                 upd_valid,
    input  logic [PC_WIDTH-1:0]  upd_pc,
    input  logic                 upd_taken,
    input  logic [SUM_WIDTH-1:0] upd_sum,
    input  logic [HISTORY-1:0]   upd_hist,
    output logic                 mispredict
`ifdef PERCEPTRON_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stat_lookups,
    output logic [CNT_WIDTH-1:0] stat_updates,
    output logic [CNT_WIDTH-1:0] stat_mispredicts,
    output logic [CNT_WIDTH-1:0] stat_trains
`endif
);

    localparam int IDX_W = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;

    localparam logic signed [WIDTH_WORD-1:0] W_MAX = {1'b0, {(WIDTH_WORD-1){1'b1}}};
    localparam logic signed [WIDTH_WORD-1:0] W_MIN = {1'b1, {(WIDTH_WORD-1){1'b0}}};
    localparam logic signed [WIDTH_WORD-1:0] W_ONE = {{(WIDTH_WORD-1){1'b0}}, 1'b1};
    localparam logic [SUM_WIDTH:0]           THETA_X = (SUM_WIDTH+1)'(THETA);

    // Sign-extend a weight to the dot-product width.
    function automatic logic signed [SUM_WIDTH-1:0] sext(input logic signed [WIDTH_WORD-1:0] v);
        return {{(SUM_WIDTH-WIDTH_WORD){v[WIDTH_WORD-1]}}, v};
    endfunction

    // Add +1 or -1 to a weight, clamping at the weight range limits.
    function automatic logic signed [WIDTH_WORD-1:0] sat_step(input logic signed [WIDTH_WORD-1:0] v,
                                                              input logic up);
        logic signed [WIDTH_WORD-1:0] r;
        if (up) begin
            r = (v == W_MAX) ? v : v + W_ONE;
        end else begin
            r = (v == W_MIN) ? v : v - W_ONE;
        end
        return r;
    endfunction

    // Weight storage. Every entry is a flop: a whole row is read for the lookup
    // and a whole row is written for training, and reset must clear everything.
    logic signed [WIDTH_WORD-1:0] bias_q [LUT_DEPTH];
    logic signed [WIDTH_WORD-1:0] w_q    [LUT_DEPTH][HISTORY];

    logic [HISTORY-1:0] ghr_q, ghr_d;

    logic                 pred_out_valid_q;
    logic                 pred_taken_q;
    logic [SUM_WIDTH-1:0] pred_sum_q;
    logic [HISTORY-1:0]   pred_hist_q;

    // ---------------------------------------------------------------- lookup
    logic [IDX_W-1:0]            lk_row;
    logic signed [SUM_WIDTH-1:0] lk_sum;
    logic                        lk_taken;

    assign lk_row = pred_pc[IDX_W-1:0];

    always_comb begin
        lk_sum = sext(bias_q[lk_row]);
        for (int i = 0; i < HISTORY; i++) begin
            if (ghr_q[i]) begin
                lk_sum = lk_sum + sext(w_q[lk_row][i]);
            end else begin
                lk_sum = lk_sum - sext(w_q[lk_row][i]);
            end
        end
        lk_taken = ~lk_sum[SUM_WIDTH-1];
    end

    // ------------------------------------------------------ resolve / train
    logic [IDX_W-1:0]           up_row;
    logic signed [SUM_WIDTH:0]  upd_sum_x;
    logic [SUM_WIDTH:0]         upd_abs;
    logic                       train_en;
    logic signed [WIDTH_WORD-1:0] tr_bias_d;
    logic signed [WIDTH_WORD-1:0] tr_w_d [HISTORY];

    assign up_row = upd_pc[IDX_W-1:0];

    // The predicted direction was ~sign(upd_sum).
    assign mispredict = upd_valid & (upd_taken != ~upd_sum[SUM_WIDTH-1]);

    // Widen by one bit before negating so that the most negative sum has a
    // representable magnitude.
    assign upd_sum_x = {upd_sum[SUM_WIDTH-1], upd_sum};
    assign upd_abs   = upd_sum_x[SUM_WIDTH] ? 1'($unsigned(-upd_sum_x)) == 1'b0 ? $unsigned(-upd_sum_x) : $unsigned(-upd_sum_x)
                                            : $unsigned(upd_sum_x);
    assign train_en  = upd_valid & (mispredict | (upd_abs <= THETA_X));

    assign tr_bias_d = sat_step(bias_q[up_row], upd_taken);

    generate
        for (genvar gi = 0; gi < HISTORY; gi++) begin : g_train
            // A weight is reinforced when its history bit agreed with the outcome.
            assign tr_w_d[gi] = sat_step(w_q[up_row][gi], upd_taken == upd_hist[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < LUT_DEPTH; r++) begin
                bias_q[r] <= '0;
                for (int i = 0; i < HISTORY; i++) begin
                    w_q[r][i] <= '0;
                end
            end
        end else if (train_en) begin
            bias_q[up_row] <= tr_bias_d;
            for (int i = 0; i < HISTORY; i++) begin
                w_q[up_row][i] <= tr_w_d[i];
            end
        end
    end

    // ------------------------------------------------------------------ GHR
    // A mispredict restores the checkpoint carried with the branch and appends
    // the real outcome. This overrides any speculative shift in the same cycle.
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict) begin
            ghr_d = {upd_hist[HISTORY-2:0], upd_taken};
        end else if (pred_valid) begin
            ghr_d = {ghr_q[HISTORY-2:0], lk_taken};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q            <= '0;
            pred_out_valid_q <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_sum_q       <= '0;
            pred_hist_q      <= '0;
        end else begin
            ghr_q            <= ghr_d;
            pred_out_valid_q <= pred_valid;
            if (pred_valid) begin
                pred_taken_q <= lk_taken;
                pred_sum_q   <= lk_sum;
                pred_hist_q  <= ghr_q;
            end
        end
    end

    assign pred_out_valid = pred_out_valid_q;
    assign pred_taken     = pred_taken_q;
    assign pred_sum       = pred_sum_q;
    assign pred_hist      = pred_hist_q;

`ifdef PERCEPTRON_STATS_EN
    // ------------------------------------------------------------ statistics
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] lookups_q, updates_q, mispredicts_q, trains_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lookups_q     <= '0;
            updates_q     <= '0;
            mispredicts_q <= '0;
            trains_q      <= '0;
        end else begin
            if (pred_valid) lookups_q     <= lookups_q + CNT_ONE;
            if (upd_valid)  updates_q     <= updates_q + CNT_ONE;
            if (mispredict) mispredicts_q <= mispredicts_q + CNT_ONE;
            if (train_en)   trains_q      <= trains_q + CNT_ONE;
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_updates     = updates_q;
    assign stat_mispredicts = mispredicts_q;
    assign stat_trains      = trains_q;
`endif

    // PC bits above the row index do not select anything.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc, upd_pc};

endmodule

// File: tb/tb_perceptron_predictor_v2.sv
// -----------------------------------------------------------------------------
// Testbench for perceptron_predictor_v2 (default parameters).
// The reference model keeps the weight table, GHR and expected outputs as plain
// integers. It is advanced once per active clock edge with the inputs the DUT
// sampled there. A negedge process compares the DUT outputs with the model on
// every cycle. Directed steps add hand-computed literal checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_perceptron_predictor_v2;

    localparam int ROWS  = 32;
    localparam int HIST  = 4;
    localparam int THETA = 21;
    localparam int WMAX  = 7;
    localparam int WMIN  = -8;

    logic       clk;
    logic       reset;
    logic       pred_valid;
    logic [7:0] pred_pc;
    logic       pred_out_valid;
    logic       pred_taken;
    logic [7:0] pred_sum;
    logic [3:0] pred_hist;
    logic       upd_valid;
    logic [7:0] upd_pc;
    logic       upd_taken;
    logic [7:0] upd_sum;
    logic [3:0] upd_hist;
    logic       mispredict;
`ifdef PERCEPTRON_STATS_EN
    logic [31:0] stat_lookups, stat_updates, stat_mispredicts, stat_trains;
`endif

    perceptron_predictor_v2 dut (
        .clk            (clk),
        .reset          (reset),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_out_valid (pred_out_valid),
        .pred_taken     (pred_taken),
        .pred_sum       (pred_sum),
        .pred_hist      (pred_hist),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_sum        (upd_sum),
        .upd_hist       (upd_hist),
        .mispredict     (mispredict)
`ifdef PERCEPTRON_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts),
        .stat_trains      (stat_trains)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------------------------------------------------------- model
    int m_bias [ROWS];
    int m_w    [ROWS][HIST];
    int m_ghr;
    int exp_ov, exp_taken, exp_sum, exp_hist;
    int m_lk, m_up, m_mp, m_tr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > WMAX) return WMAX;
        if (v < WMIN) return WMIN;
        return v;
    endfunction

    function automatic int model_mp();
        int s;
        s = $signed(upd_sum);
        return (upd_valid && (int'(upd_taken) != int'(s >= 0))) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++) begin
            m_bias[r] = 0;
            for (int i = 0; i < HIST; i++) m_w[r][i] = 0;
        end
        m_ghr = 0;
        exp_ov = 0; exp_taken = 0; exp_sum = 0; exp_hist = 0;
        m_lk = 0; m_up = 0; m_mp = 0; m_tr = 0;
    endtask

    // One active edge: the lookup sees the weights from before any training in
    // the same edge.
    task automatic model_step();
        int row, s, tk, mp, us, tr;
        s  = 0;
        tk = 0;
        if (pred_valid) begin
            row = int'(pred_pc) % ROWS;
            s = m_bias[row];
            for (int i = 0; i < HIST; i++)
                s += ((m_ghr >> i) & 1) ? m_w[row][i] : -m_w[row][i];
            tk = (s >= 0) ? 1 : 0;
        end
        mp = model_mp();
        us = $signed(upd_sum);
        if (us < 0) us = -us;
        tr = (upd_valid && (mp == 1 || us <= THETA)) ? 1 : 0;

        exp_ov = pred_valid ? 1 : 0;
        if (pred_valid) begin
            exp_taken = tk;
            exp_sum   = s;
            exp_hist  = m_ghr;
        end
        if (tr == 1) begin
            row = int'(upd_pc) % ROWS;
            m_bias[row] = clamp(m_bias[row] + (upd_taken ? 1 : -1));
            for (int i = 0; i < HIST; i++)
                m_w[row][i] = clamp(m_w[row][i] + ((upd_taken == upd_hist[i]) ? 1 : -1));
        end
        if (mp == 1)
            m_ghr = ((int'(upd_hist) << 1) | int'(upd_taken)) & 15;
        else if (pred_valid)
            m_ghr = ((m_ghr << 1) | tk) & 15;

        if (pred_valid) m_lk++;
        if (upd_valid)  m_up++;
        if (mp == 1)    m_mp++;
        if (tr == 1)    m_tr++;
    endtask

    // ------------------------------------------------------- compare process
    always @(negedge clk) begin
        chk("out_valid", 32'(pred_out_valid), exp_ov);
        chk("taken", 32'(pred_taken), exp_taken);
        chk("sum", 32'($signed(pred_sum)), exp_sum);
        chk("hist", 32'(pred_hist), exp_hist);
        chk("mispredict", 32'(mispredict), model_mp());
`ifdef PERCEPTRON_STATS_EN
        chk("stat_lookups", stat_lookups, m_lk);
        chk("stat_updates", stat_updates, m_up);
        chk("stat_mispredicts", stat_mispredicts, m_mp);
        chk("stat_trains", stat_trains, m_tr);
`endif
    end

    // ---------------------------------------------------------------- driver
    task automatic drive(input bit pv, input int ppc, input bit uv, input int upc,
                         input bit ut, input int us, input int uh);
        pred_valid = pv;
        pred_pc    = 8'(ppc);
        upd_valid  = uv;
        upd_pc     = 8'(upc);
        upd_taken  = ut;
        upd_sum    = 8'(us);
        upd_hist   = 4'(uh);
    endtask

    // Drive one cycle of inputs, then return at edge+1 with the outputs updated.
    task automatic cycle(input bit pv, input int ppc, input bit uv, input int upc,
                         input bit ut, input int us, input int uh);
        drive(pv, ppc, uv, upc, ut, us, uh);
        @(posedge clk);
        if (reset) model_step();
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Force the GHR to h with a mispredicting update on a scratch row.
    task automatic set_ghr(input int h);
        cycle(0, 0, 1, 31, bit'(h & 1), (h & 1) ? -1 : 0, h >> 1);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        chk("reset_out_valid", 32'(pred_out_valid), 0);
        chk("reset_sum", 32'(pred_sum), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // First lookup after reset: all-zero row, so the sum is 0 and taken.
        cycle(1, 5, 0, 0, 0, 0, 0);
        chk("t1_valid", 32'(pred_out_valid), 1);
        chk("t1_taken", 32'(pred_taken), 1);
        chk("t1_sum", 32'(pred_sum), 0);
        chk("t1_hist", 32'(pred_hist), 0);

        // Train row 5 towards not-taken. Expect bias -1, w +1, GHR restored to 0.
        cycle(0, 0, 1, 5, 0, 0, 0);
        chk("t2_mispredict", 32'(mispredict), 1);
        cycle(1, 5, 0, 0, 0, 0, 0);
        chk("t2_sum", 32'(pred_sum), 32'h0000_00FB);
        chk("t2_taken", 32'(pred_taken), 0);
        chk("t2_hist", 32'(pred_hist), 0);
        idle();

        // Saturation on row 3.
        for (int k = 0; k < 10; k++) cycle(0, 0, 1, 3, 1, 0, 15);
        set_ghr(15);
        cycle(1, 3, 0, 0, 0, 0, 0);
        chk("sat_sum", 32'($signed(pred_sum)), 35);
        chk("sat_hist", 32'(pred_hist), 15);
        cycle(0, 0, 1, 3, 1, 35, 15);   // confident and correct: no training
        set_ghr(15);
        cycle(1, 3, 0, 0, 0, 0, 0);
        chk("sat_sum_hold", 32'($signed(pred_sum)), 35);

        // |upd_sum| boundary around THETA and the most negative sum.
        cycle(0, 0, 1, 12, 1, 21, 0);
        cycle(0, 0, 1, 12, 1, 22, 0);
        cycle(0, 0, 1, 12, 0, -21, 5);
        cycle(0, 0, 1, 12, 0, -128, 5);
        cycle(0, 0, 1, 12, 1, -128, 5);
        cycle(1, 12, 0, 0, 0, 0, 0);
        idle();

        // Speculative history and mispredict override.
        do_reset();
        cycle(1, 10, 0, 0, 0, 0, 0);
        chk("spec_h0", 32'(pred_hist), 0);
        cycle(1, 10, 0, 0, 0, 0, 0);
        chk("spec_h1", 32'(pred_hist), 1);
        cycle(1, 10, 1, 9, 0, 0, 0);
        chk("spec_h2", 32'(pred_hist), 3);
        cycle(1, 10, 0, 0, 0, 0, 0);
        chk("spec_restore", 32'(pred_hist), 0);
        idle();

        // Same-row lookup and training.
        do_reset();
        cycle(1, 7, 1, 7, 1, 0, 0);
        chk("coll_old", 32'($signed(pred_sum)), 0);
        cycle(1, 7, 0, 0, 0, 0, 0);
        chk("coll_new", 32'($signed(pred_sum)), 3);
        chk("coll_taken", 32'(pred_taken), 1);

        // Randomised traffic.
        for (int k = 0; k < 800; k++) begin
            cycle(bit'($urandom_range(0, 1)), $urandom_range(0, 15),
                  bit'($urandom_range(0, 1)), $urandom_range(0, 15),
                  bit'($urandom_range(0, 1)), $urandom_range(0, 255),
                  $urandom_range(0, 15));
        end

        // Reset asserted between a lookup and its use.
        cycle(1, 7, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        chk("async_out_valid", 32'(pred_out_valid), 0);
        chk("async_sum", 32'(pred_sum), 0);
`ifdef PERCEPTRON_STATS_EN
        chk("async_stat_lookups", stat_lookups, 0);
        chk("async_stat_trains", stat_trains, 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Post-reset random traffic.
        for (int k = 0; k < 200; k++) begin
            cycle(bit'($urandom_range(0, 1)), $urandom_range(0, 31),
                  bit'($urandom_range(0, 1)), $urandom_range(0, 31),
                  bit'($urandom_range(0, 1)), $urandom_range(0, 255),
                  $urandom_range(0, 15));
        end
        idle();
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
